// File: rtl/vec_ldst_seq_pkg.sv
// Shared constants and state encoding for the vector load/store sequencer.
package vec_ldst_seq_pkg;

  localparam int unsigned Elems  = 16;  // elements per vector, also the serial burst length
  localparam int unsigned DataW  = 16;  // element width
  localparam int unsigned MaddrW = 16;  // memory address width
  localparam int unsigned RdLat  = 1;   // RD_s strobe to DataIn_s latency in cycles

  localparam int unsigned IdxW = $clog2(Elems);
  // Counter must reach Elems+RdLat-1 while draining register-file reads.
  localparam int unsigned CntW = $clog2(Elems + RdLat);

  localparam logic OpLoad  = 1'b0;
  localparam logic OpStore = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StMemRd,
    StVrWr,
    StVrRd,
    StMemWr,
    StDone
  } state_e;

endpackage

// File: rtl/vec_elem_buf.sv
// Element staging buffer: indexed synchronous write, combinational indexed read.
module vec_elem_buf #(
  parameter int unsigned Elems = 16,
  parameter int unsigned DataW = 16,
  parameter int unsigned IdxW  = $clog2(Elems)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [IdxW-1:0]  waddr_i,
  input  logic [DataW-1:0] wdata_i,
  input  logic [IdxW-1:0]  raddr_i,
  output logic [DataW-1:0] rdata_o
);

  logic [DataW-1:0] mem_q [Elems];

  // Contents carry no reset; every op fully rewrites the elements it later reads.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/vec_ldst_seq.sv
// Vector load/store sequencer: moves one vector between strided memory and the
// register file's serial port. Memory traffic is staged in a buffer so the
// register-file burst always runs for Elems contiguous cycles.
module vec_ldst_seq
  import vec_ldst_seq_pkg::*;
(
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Start,
  input  logic              Op,
  input  logic [2:0]        VAddr,
  input  logic [MaddrW-1:0] BaseAddr,
  input  logic [MaddrW-1:0] Stride,
  output logic              Busy,
  output logic              Done,
  output logic [2:0]        Addr,
  output logic              RD_s,
  output logic              WR_s,
  output logic [DataW-1:0]  DataOut_s,
  input  logic [DataW-1:0]  DataIn_s,
  output logic [MaddrW-1:0] MemAddr,
  output logic              MemRd,
  output logic              MemWr,
  output logic [DataW-1:0]  MemWData,
  input  logic [DataW-1:0]  MemRData,
  input  logic              MemReady
);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [2:0]        vaddr_q, vaddr_d;
  logic [MaddrW-1:0] stride_q, stride_d;
  logic [MaddrW-1:0] mem_addr_q, mem_addr_d;

  logic              last_elem, rd_last;
  logic [IdxW-1:0]   rd_idx;
  logic              buf_we;
  logic [IdxW-1:0]   buf_waddr;
  logic [DataW-1:0]  buf_wdata, buf_rdata;

  assign last_elem = (cnt_q == CntW'(Elems - 1));
  assign rd_last   = (cnt_q == CntW'(Elems + RdLat - 1));
  // Element captured this cycle was strobed RdLat cycles ago.
  assign rd_idx    = IdxW'(cnt_q - CntW'(RdLat));

  // State register; async reset aborts any op in flight without a Done.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; the state itself records whether this is a load or a store.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (Start) state_d = (Op == OpStore) ? StVrRd : StMemRd;
      StMemRd: if (MemReady && last_elem) state_d = StVrWr;
      StVrWr:  if (last_elem) state_d = StDone;
      StVrRd:  if (rd_last) state_d = StMemWr;
      StMemWr: if (MemReady && last_elem) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath registers: latched operands, element counter and running memory address.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt_q      <= '0;
      vaddr_q    <= '0;
      stride_q   <= '0;
      mem_addr_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      vaddr_q    <= vaddr_d;
      stride_q   <= stride_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  // Datapath next values; the address accumulates Stride, wrapping modulo 2^MaddrW.
  always_comb begin
    cnt_d      = cnt_q;
    vaddr_d    = vaddr_q;
    stride_d   = stride_q;
    mem_addr_d = mem_addr_q;
    unique case (state_q)
      StIdle: begin
        if (Start) begin
          vaddr_d    = VAddr;
          stride_d   = Stride;
          mem_addr_d = BaseAddr;
          cnt_d      = '0;
        end
      end
      StMemRd, StMemWr: begin
        if (MemReady) begin
          mem_addr_d = mem_addr_q + stride_q;
          cnt_d      = last_elem ? '0 : cnt_q + CntW'(1);
        end
      end
      StVrWr:  cnt_d = last_elem ? '0 : cnt_q + CntW'(1);
      StVrRd:  cnt_d = rd_last ? '0 : cnt_q + CntW'(1);
      default: cnt_d = '0;
    endcase
  end

  // Outputs and buffer controls, decoded purely from state so reset drops them at once.
  always_comb begin
    Busy      = (state_q != StIdle);
    Addr      = Busy ? vaddr_q : 3'd0;
    Done      = 1'b0;
    RD_s      = 1'b0;
    WR_s      = 1'b0;
    DataOut_s = '0;
    MemAddr   = '0;
    MemRd     = 1'b0;
    MemWr     = 1'b0;
    MemWData  = '0;
    buf_we    = 1'b0;
    buf_waddr = '0;
    buf_wdata = '0;
    unique case (state_q)
      StMemRd: begin
        MemRd     = 1'b1;
        MemAddr   = mem_addr_q;
        buf_we    = MemReady;
        buf_waddr = cnt_q[IdxW-1:0];
        buf_wdata = MemRData;
      end
      StVrWr: begin
        WR_s      = 1'b1;
        DataOut_s = buf_rdata;
      end
      StVrRd: begin
        RD_s      = (cnt_q < CntW'(Elems));
        buf_we    = (cnt_q >= CntW'(RdLat));
        buf_waddr = rd_idx;
        buf_wdata = DataIn_s;
      end
      StMemWr: begin
        MemWr    = 1'b1;
        MemAddr  = mem_addr_q;
        MemWData = buf_rdata;
      end
      StDone:  Done = 1'b1;
      default: ;
    endcase
  end

  vec_elem_buf #(
    .Elems (Elems),
    .DataW (DataW),
    .IdxW  (IdxW)
  ) u_buf (
    .clk_i   (Clk),
    .we_i    (buf_we),
    .waddr_i (buf_waddr),
    .wdata_i (buf_wdata),
    .raddr_i (cnt_q[IdxW-1:0]),
    .rdata_o (buf_rdata)
  );

endmodule

// File: tb/tb_vec_ldst_seq.sv
// Scoreboard bench for vec_ldst_seq: stimulus queues expected register-file
// writes, memory requests and Done cycles; a negedge monitor pops and compares.
module tb_vec_ldst_seq;
  import vec_ldst_seq_pkg::*;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] d;
  } mw_t;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        Start = 1'b0;
  logic        Op = 1'b0;
  logic [2:0]  VAddr = 3'd0;
  logic [15:0] BaseAddr = 16'h0;
  logic [15:0] Stride = 16'h0;
  logic        Busy, Done, RD_s, WR_s, MemRd, MemWr, MemReady;
  logic [2:0]  Addr;
  logic [15:0] DataOut_s, MemAddr, MemWData, MemRData;
  logic [15:0] DataIn_s = 16'h0;

  logic        ready_all = 1'b1;
  int          cyc = 0;
  logic [15:0] rf [16];
  logic [3:0]  rf_idx = 4'd0;

  logic [15:0] exp_wr_q [$];
  logic [15:0] exp_rd_q [$];
  mw_t         exp_mw_q [$];
  int          exp_done_q [$];
  logic [2:0]  exp_vaddr = 3'd0;

  int tests = 0;
  int fails = 0;

  vec_ldst_seq dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .Start     (Start),
    .Op        (Op),
    .VAddr     (VAddr),
    .BaseAddr  (BaseAddr),
    .Stride    (Stride),
    .Busy      (Busy),
    .Done      (Done),
    .Addr      (Addr),
    .RD_s      (RD_s),
    .WR_s      (WR_s),
    .DataOut_s (DataOut_s),
    .DataIn_s  (DataIn_s),
    .MemAddr   (MemAddr),
    .MemRd     (MemRd),
    .MemWr     (MemWr),
    .MemWData  (MemWData),
    .MemRData  (MemRData),
    .MemReady  (MemReady)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  // Memory model: zero-wait or ready every third cycle; data is address ^ A000.
  assign MemReady = ready_all || (cyc % 3 == 0);
  assign MemRData = MemAddr ^ 16'hA000;

  // Register-file serial read model: index restarts whenever the strobe is low.
  always @(posedge Clk) begin
    if (RD_s) begin
      DataIn_s <= rf[rf_idx];
      rf_idx   <= rf_idx + 4'd1;
    end else begin
      rf_idx <= 4'd0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic miss(input string name);
    tests++;
    fails++;
    $display("FAIL %s: unexpected DUT event, got 1, expected 0", name);
  endtask

  function automatic void push_op(input logic op, input logic [15:0] base,
                                  input logic [15:0] str);
    logic [15:0] a;
    for (int j = 0; j < 16; j++) begin
      a = base + 16'(j) * str;
      if (op == 1'b0) begin
        exp_rd_q.push_back(a);
        exp_wr_q.push_back(a ^ 16'hA000);
      end else begin
        exp_mw_q.push_back('{a: a, d: rf[j]});
      end
    end
  endfunction

  // One-cycle Start pulse from IDLE; done_off < 0 means Done cycle is not pinned.
  task automatic issue(input logic op, input logic [2:0] va, input logic [15:0] base,
                       input logic [15:0] str, input int done_off, output int c);
    @(negedge Clk);
    check("idle_busy", {31'b0, Busy}, 0);
    Op = op; VAddr = va; BaseAddr = base; Stride = str;
    Start = 1'b1;
    c = cyc;
    exp_vaddr = va;
    push_op(op, base, str);
    exp_done_q.push_back(done_off < 0 ? -1 : c + done_off);
    @(negedge Clk);
    Start = 1'b0;
    check("busy_after_start", {31'b0, Busy}, 1);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_done_q.size() != 0 && n < budget) begin
      @(negedge Clk);
      n++;
    end
    check("done_drain", exp_done_q.size(), 0);
    exp_done_q.delete();
    @(negedge Clk);
  endtask

  // Monitor: compares every observable DUT event against the scoreboard queues.
  initial begin
    int          wr_run, rd_run, mrd_cnt, ed;
    logic        prev_done, pend;
    logic [1:0]  pend_kind;
    logic [15:0] pend_addr, e;
    mw_t         m;
    wr_run = 0; rd_run = 0; mrd_cnt = 0;
    prev_done = 1'b0; pend = 1'b0; pend_kind = 2'b0; pend_addr = 16'h0;
    forever begin
      @(negedge Clk);
      if (!Rst_n) begin
        wr_run = 0; rd_run = 0; mrd_cnt = 0; prev_done = 1'b0; pend = 1'b0;
      end else begin
        if (RD_s || WR_s) check("rd_wr_exclusive", {31'b0, RD_s & WR_s}, 0);
        if (prev_done) check("busy_after_done", {31'b0, Busy}, 0);
        if (pend) begin
          check("mem_hold_addr", MemAddr, pend_addr);
          check("mem_hold_kind", {30'b0, MemWr, MemRd}, pend_kind);
        end
        pend      = (MemRd || MemWr) && !MemReady;
        pend_kind = {MemWr, MemRd};
        pend_addr = MemAddr;

        if (WR_s) begin
          if (wr_run == 0) begin
            check("wr_after_reads", mrd_cnt, 16);
            mrd_cnt = 0;
          end
          wr_run++;
          check("wr_vaddr", Addr, exp_vaddr);
          if (exp_wr_q.size() == 0) miss("wr_unexpected");
          else begin
            e = exp_wr_q.pop_front();
            check("wr_data", DataOut_s, e);
          end
        end else if (wr_run != 0) begin
          check("wr_burst_len", wr_run, 16);
          wr_run = 0;
        end

        if (RD_s) begin
          rd_run++;
          check("rd_vaddr", Addr, exp_vaddr);
        end else if (rd_run != 0) begin
          check("rd_burst_len", rd_run, 16);
          rd_run = 0;
        end

        if (MemRd && MemReady) begin
          mrd_cnt++;
          if (exp_rd_q.size() == 0) miss("memrd_unexpected");
          else begin
            e = exp_rd_q.pop_front();
            check("memrd_addr", MemAddr, e);
          end
        end

        if (MemWr && MemReady) begin
          if (exp_mw_q.size() == 0) miss("memwr_unexpected");
          else begin
            m = exp_mw_q.pop_front();
            check("memwr_addr", MemAddr, m.a);
            check("memwr_data", MemWData, m.d);
          end
        end

        if (Done) begin
          check("done_busy", {31'b0, Busy}, 1);
          if (exp_done_q.size() == 0) miss("done_unexpected");
          else begin
            ed = exp_done_q.pop_front();
            if (ed >= 0) check("done_cycle", cyc, ed);
          end
        end
        prev_done = Done;
      end
    end
  end

  // Directed stimulus.
  initial begin
    int c;
    for (int j = 0; j < 16; j++) rf[j] = 16'hB000 + 16'(j);

    repeat (2) @(negedge Clk);
    check("rst_ctrl", {26'b0, Busy, Done, RD_s, WR_s, MemRd, MemWr}, 0);
    check("rst_addr", {29'b0, Addr}, 0);
    check("rst_memaddr", MemAddr, 0);
    check("rst_data", {DataOut_s, MemWData}, 0);
    Rst_n = 1'b1;

    // Zero-wait load: A100..A10F, Done 33 cycles after Start.
    ready_all = 1'b1;
    issue(1'b0, 3'd2, 16'h0100, 16'h0001, 33, c);
    wait_drain(100);

    // Load with memory ready every third cycle.
    ready_all = 1'b0;
    issue(1'b0, 3'd3, 16'h0100, 16'h0001, -1, c);
    wait_drain(300);
    ready_all = 1'b1;

    // Store with address wrap: FFF8, FFFA, .., 0016; data B000..B00F.
    issue(1'b1, 3'd5, 16'hFFF8, 16'h0002, 34, c);
    wait_drain(100);

    // Start pulse while busy must be ignored.
    issue(1'b0, 3'd1, 16'h0200, 16'h0003, 33, c);
    repeat (9) @(negedge Clk);
    Op = 1'b1; BaseAddr = 16'h1234; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0; Op = 1'b0;
    wait_drain(100);

    // Start held high through DONE: second op launches only from IDLE.
    @(negedge Clk);
    check("held_idle_busy", {31'b0, Busy}, 0);
    Op = 1'b0; VAddr = 3'd6; BaseAddr = 16'h0300; Stride = 16'h0010;
    exp_vaddr = 3'd6;
    Start = 1'b1;
    c = cyc;
    push_op(1'b0, 16'h0300, 16'h0010);
    push_op(1'b0, 16'h0300, 16'h0010);
    exp_done_q.push_back(c + 33);
    exp_done_q.push_back(c + 67);
    repeat (35) @(negedge Clk);
    Start = 1'b0;
    wait_drain(100);

    // Reset at VR_WR element 7: strobe drops at once, no Done.
    issue(1'b0, 3'd4, 16'h0400, 16'h0001, 33, c);
    repeat (23) @(negedge Clk);
    #1;
    Rst_n = 1'b0;
    exp_wr_q.delete();
    exp_done_q.delete();
    #1;
    check("rst_mid_wr_s", {31'b0, WR_s}, 0);
    check("rst_mid_busy", {31'b0, Busy}, 0);
    check("rst_mid_addr", {29'b0, Addr}, 0);
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    issue(1'b0, 3'd4, 16'h0500, 16'h0001, 33, c);
    wait_drain(100);

    check("end_wr_q", exp_wr_q.size(), 0);
    check("end_rd_q", exp_rd_q.size(), 0);
    check("end_mw_q", exp_mw_q.size(), 0);
    check("end_done_q", exp_done_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
